// File: rtl/issue_prf_wbarb.sv
// Writeback arbiter: two per-source result FIFOs arbitrated onto PRF write port A.
// Define ISSUE_PRF_WBARB_FIXED_PRIO_EN for fixed source-0 priority (default: round-robin).
module issue_prf_wbarb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s0_valid_i,
  output logic                  s0_ready_o,
  input  logic [ADDR_WIDTH-1:0] s0_addr_i,
  input  logic [DATA_WIDTH-1:0] s0_data_i,
  input  logic                  s1_valid_i,
  output logic                  s1_ready_o,
  input  logic [ADDR_WIDTH-1:0] s1_addr_i,
  input  logic [DATA_WIDTH-1:0] s1_data_i,
  output logic [ADDR_WIDTH-1:0] prf_addra_o,
  output logic                  prf_wea_o,
  output logic [DATA_WIDTH-1:0] prf_dina_o,
  output logic                  busy_clr_valid_o,
  output logic [ADDR_WIDTH-1:0] busy_clr_addr_o,
  output logic                  idle_o
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [1:0]       src_valid;
  logic [1:0]       push;
  logic [1:0]       grant;
  logic [1:0]       empty;
  logic [1:0]       full;
  logic [ENT_W-1:0] src_entry [2];
  logic [ENT_W-1:0] head [2];

  assign src_valid    = {s1_valid_i, s0_valid_i};
  assign src_entry[0] = {s0_addr_i, s0_data_i};
  assign src_entry[1] = {s1_addr_i, s1_data_i};
  assign s0_ready_o   = ~full[0];
  assign s1_ready_o   = ~full[1];

  // A pop in the same cycle never frees room for a push: ready depends on full alone.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    assign empty[gi] = (wr_ptr_q == rd_ptr_q);
    assign full[gi]  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push[gi]  = src_valid[gi] & ~full[gi];
    assign head[gi]  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign wr_ptr_d  = wr_ptr_q + {{(PTR_W-1){1'b0}}, push[gi]};
    assign rd_ptr_d  = rd_ptr_q + {{(PTR_W-1){1'b0}}, grant[gi]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[gi]) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= src_entry[gi];
      end
    end
  end

`ifdef ISSUE_PRF_WBARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (!empty[0]) begin
      grant = 2'b01;
    end else if (!empty[1]) begin
      grant = 2'b10;
    end
  end
`else
  // last_grant_q is 1 when source 1 won most recently, so source 0 wins the first tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (!empty[0] && !empty[1]) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else if (!empty[0]) begin
      grant = 2'b01;
    end else if (!empty[1]) begin
      grant = 2'b10;
    end
    if (grant != 2'b00) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  logic                  prf_wea_q, prf_wea_d;
  logic [ADDR_WIDTH-1:0] prf_addra_q, prf_addra_d;
  logic [DATA_WIDTH-1:0] prf_dina_q, prf_dina_d;

  // Address and data hold their last value on idle cycles; only the enable drops.
  always_comb begin
    prf_wea_d   = |grant;
    prf_addra_d = prf_addra_q;
    prf_dina_d  = prf_dina_q;
    if (grant[1]) begin
      {prf_addra_d, prf_dina_d} = head[1];
    end else if (grant[0]) begin
      {prf_addra_d, prf_dina_d} = head[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prf_wea_q   <= 1'b0;
      prf_addra_q <= '0;
      prf_dina_q  <= '0;
    end else begin
      prf_wea_q   <= prf_wea_d;
      prf_addra_q <= prf_addra_d;
      prf_dina_q  <= prf_dina_d;
    end
  end

  assign prf_wea_o        = prf_wea_q;
  assign prf_addra_o      = prf_addra_q;
  assign prf_dina_o       = prf_dina_q;
  assign busy_clr_valid_o = prf_wea_q;
  assign busy_clr_addr_o  = prf_addra_q;
  assign idle_o           = empty[0] & empty[1] & ~prf_wea_q;

endmodule

// File: tb/tb_issue_prf_wbarb.sv
// Directed self-checking bench for issue_prf_wbarb (both arbitration modes).
module tb_issue_prf_wbarb;
  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic [AW-1:0] prf_addra, busy_clr_addr;
  logic          prf_wea, busy_clr_valid, idle;
  logic [DW-1:0] prf_dina;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_cyc  [$];

  issue_prf_wbarb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s0_valid_i(s0_valid), .s0_ready_o(s0_ready), .s0_addr_i(s0_addr), .s0_data_i(s0_data),
    .s1_valid_i(s1_valid), .s1_ready_o(s1_ready), .s1_addr_i(s1_addr), .s1_data_i(s1_data),
    .prf_addra_o(prf_addra), .prf_wea_o(prf_wea), .prf_dina_o(prf_dina),
    .busy_clr_valid_o(busy_clr_valid), .busy_clr_addr_o(busy_clr_addr), .idle_o(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (prf_wea === 1'b1) begin
      log_addr.push_back(prf_addra);
      log_data.push_back(prf_dina);
      log_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] dat(input int a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic apply_reset;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    clear_log;
    tick;
  endtask

  task automatic test_reset;
    string       nm [8];
    logic [63:0] ob [8];
    logic [63:0] ex [8];
    #1 rst_n = 1'b0;
    #2;
    nm = '{"wea", "addra", "dina", "bclr_valid", "bclr_addr", "s0_ready", "s1_ready", "idle"};
    ob = '{64'(prf_wea), 64'(prf_addra), prf_dina, 64'(busy_clr_valid), 64'(busy_clr_addr),
           64'(s0_ready), 64'(s1_ready), 64'(idle)};
    ex = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1, 64'd1};
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (ob[i] !== ex[i]) begin
        tests_failed++;
        $display("FAIL reset_%s got %h expected %h", nm[i], ob[i], ex[i]);
      end
    end
    tick;
    rst_n = 1'b1;
    tick;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_push;
    s0_valid = 1'b1; s0_addr = 6'd5; s0_data = 64'hDEAD;
    tick;
    s0_valid = 1'b0;
    tests_run++;
    if ({prf_wea, idle} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_after_push wea/idle got %b expected 00", {prf_wea, idle});
    end
    tick;
    tests_run++;
    if ({prf_wea, busy_clr_valid, idle} !== 3'b110) begin
      tests_failed++;
      $display("FAIL single_write wea/bclr/idle got %b expected 110", {prf_wea, busy_clr_valid, idle});
    end
    tests_run++;
    if (prf_addra !== 6'd5 || busy_clr_addr !== 6'd5) begin
      tests_failed++;
      $display("FAIL single_addr addra %0d bclr_addr %0d expected 5", prf_addra, busy_clr_addr);
    end
    tests_run++;
    if (prf_dina !== 64'hDEAD) begin
      tests_failed++;
      $display("FAIL single_data got %h expected dead", prf_dina);
    end
    tick;
    tests_run++;
    if ({prf_wea, busy_clr_valid, idle} !== 3'b001 || prf_addra !== 6'd5) begin
      tests_failed++;
      $display("FAIL single_after wea/bclr/idle %b addra %0d expected 001 addra 5",
               {prf_wea, busy_clr_valid, idle}, prf_addra);
    end
    $display("[TB] test_single_push done");
  endtask

  task automatic test_contention;
    int i0 = 0, i1 = 0;
    logic p0, p1;
    int exp_a [6];
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
`ifdef ISSUE_PRF_WBARB_FIXED_PRIO_EN
    exp_a = '{1, 2, 3, 33, 34, 35};
`else
    exp_a = '{1, 33, 2, 34, 3, 35};
`endif
    apply_reset;
    s0_valid = 1'b1; s0_addr = 6'd1;  s0_data = dat(1);
    s1_valid = 1'b1; s1_addr = 6'd33; s1_data = dat(33);
    for (int k = 0; k < 20 && (i0 < 3 || i1 < 3); k++) begin
      p0 = s0_valid & s0_ready;
      p1 = s1_valid & s1_ready;
      tick;
      if (p0) begin
        i0++;
        if (i0 < 3) begin s0_addr = AW'(1 + i0); s0_data = dat(1 + i0); end
        else s0_valid = 1'b0;
      end
      if (p1) begin
        i1++;
        if (i1 < 3) begin s1_addr = AW'(33 + i1); s1_data = dat(33 + i1); end
        else s1_valid = 1'b0;
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (8) tick;
    tests_run++;
    if (log_addr.size() != 6) begin
      tests_failed++;
      $display("FAIL contention_count got %0d writes expected 6", log_addr.size());
    end
    for (int j = 0; j < 6; j++) begin
      oa = (j < log_addr.size()) ? log_addr[j] : 'x;
      od = (j < log_data.size()) ? log_data[j] : 'x;
      tests_run++;
      if (oa !== AW'(exp_a[j]) || od !== dat(exp_a[j])) begin
        tests_failed++;
        $display("FAIL contention_order[%0d] got addr %0d data %h expected addr %0d data %h",
                 j, oa, od, exp_a[j], dat(exp_a[j]));
      end
    end
    $display("[TB] test_contention done");
  endtask

  task automatic test_full_fifo;
    int i0 = 0, i1 = 0;
    logic p0, p1, prev_r1;
    logic low_seen = 1'b0, s1w_seen = 1'b0;
    logic r_tr [4];
    logic r_ex [4];
    int n0 = 0, n1 = 0;
`ifdef ISSUE_PRF_WBARB_FIXED_PRIO_EN
    r_ex = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
    r_ex = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    apply_reset;
    s0_valid = 1'b1; s0_addr = 6'd8;  s0_data = dat(8);
    s1_valid = 1'b1; s1_addr = 6'd40; s1_data = dat(40);
    prev_r1 = s1_ready;
    for (int k = 0; k < 60 && (i0 < 6 || i1 < 6); k++) begin
      p0 = s0_valid & s0_ready;
      p1 = s1_valid & s1_ready;
      tick;
      if (p0) begin
        i0++;
        if (i0 < 6) begin s0_addr = AW'(8 + i0); s0_data = dat(8 + i0); end
        else s0_valid = 1'b0;
      end
      if (p1) begin
        i1++;
        if (i1 < 6) begin s1_addr = AW'(40 + i1); s1_data = dat(40 + i1); end
        else s1_valid = 1'b0;
      end
      if (k < 4) r_tr[k] = s1_ready;
      if (!low_seen && !s1_ready) begin
        low_seen = 1'b1;
        tests_run++;
        if (i1 != 2) begin
          tests_failed++;
          $display("FAIL full_drop s1_ready fell after %0d pushes expected 2", i1);
        end
      end
      if (!s1w_seen && prf_wea && prf_addra >= 6'd40) begin
        s1w_seen = 1'b1;
        tests_run++;
        if ({prev_r1, s1_ready} !== 2'b01) begin
          tests_failed++;
          $display("FAIL full_pop_ready ready during/after pop got %b expected 01", {prev_r1, s1_ready});
        end
      end
      prev_r1 = s1_ready;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (10) tick;
    tests_run++;
    if (!low_seen || !s1w_seen) begin
      tests_failed++;
      $display("FAIL full_events low_seen %b s1_write_seen %b expected 11", low_seen, s1w_seen);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (r_tr[k] !== r_ex[k]) begin
        tests_failed++;
        $display("FAIL full_ready_trace[%0d] got %b expected %b", k, r_tr[k], r_ex[k]);
      end
    end
    for (int j = 0; j < log_addr.size(); j++) begin
      if (log_addr[j] >= 6'd40) begin
        tests_run++;
        if (log_addr[j] !== AW'(40 + n1) || log_data[j] !== dat(40 + n1)) begin
          tests_failed++;
          $display("FAIL full_s1_seq[%0d] got addr %0d expected %0d", n1, log_addr[j], 40 + n1);
        end
        n1++;
      end else begin
        tests_run++;
        if (log_addr[j] !== AW'(8 + n0) || log_data[j] !== dat(8 + n0)) begin
          tests_failed++;
          $display("FAIL full_s0_seq[%0d] got addr %0d expected %0d", n0, log_addr[j], 8 + n0);
        end
        n0++;
      end
    end
    tests_run++;
    if (n0 != 6 || n1 != 6) begin
      tests_failed++;
      $display("FAIL full_counts got s0 %0d s1 %0d expected 6 6", n0, n1);
    end
    $display("[TB] test_full_fifo done");
  endtask

  task automatic test_pointer_wrap;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    int oc;
    clear_log;
    for (int i = 0; i < 10; i++) begin
      s0_valid = 1'b1; s0_addr = AW'(10 + i); s0_data = dat(10 + i);
      tests_run++;
      if (s0_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_ready[%0d] got %b expected 1", i, s0_ready);
      end
      tick;
    end
    s0_valid = 1'b0;
    repeat (4) tick;
    tests_run++;
    if (log_addr.size() != 10) begin
      tests_failed++;
      $display("FAIL wrap_count got %0d expected 10", log_addr.size());
    end
    for (int j = 0; j < 10; j++) begin
      oa = (j < log_addr.size()) ? log_addr[j] : 'x;
      od = (j < log_data.size()) ? log_data[j] : 'x;
      oc = (j < log_cyc.size() && log_cyc.size() > 0) ? log_cyc[j] - log_cyc[0] : -1;
      tests_run++;
      if (oa !== AW'(10 + j) || od !== dat(10 + j) || oc != j) begin
        tests_failed++;
        $display("FAIL wrap[%0d] got addr %0d data %h cycle_ofs %0d expected addr %0d data %h cycle_ofs %0d",
                 j, oa, od, oc, 10 + j, dat(10 + j), j);
      end
    end
    $display("[TB] test_pointer_wrap done");
  endtask

  task automatic test_reset_midflight;
    s0_valid = 1'b1; s0_addr = 6'd20; s0_data = dat(20);
    s1_valid = 1'b1; s1_addr = 6'd50; s1_data = dat(50);
    tick;
    s0_addr = 6'd21; s0_data = dat(21);
    s1_addr = 6'd51; s1_data = dat(51);
    tick;
    tests_run++;
    if (prf_wea !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre wea got %b expected 1", prf_wea);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({prf_wea, busy_clr_valid, s0_ready, s1_ready, idle} !== 5'b00111) begin
      tests_failed++;
      $display("FAIL midrst_assert wea/bclr/r0/r1/idle got %b expected 00111",
               {prf_wea, busy_clr_valid, s0_ready, s1_ready, idle});
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    clear_log;
    repeat (5) tick;
    tests_run++;
    if (log_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_stale got %0d writes expected 0", log_addr.size());
    end
    tests_run++;
    if ({s0_ready, s1_ready, idle} !== 3'b111) begin
      tests_failed++;
      $display("FAIL midrst_after r0/r1/idle got %b expected 111", {s0_ready, s1_ready, idle});
    end
    $display("[TB] test_reset_midflight done");
  endtask

  initial begin
    test_reset;
    test_single_push;
    test_contention;
    test_full_fifo;
    test_pointer_wrap;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
